// File: rtl/passcode_controller_if.sv
// Keypad-side bundle for the passcode controller: entry strobes, stored passcode
// configuration and the status outputs consumed by display/actuator logic.
interface passcode_controller_if #(
    parameter int DIGIT_W      = 4,
    parameter int MAX_LEN      = 10,
    parameter int MAX_ATTEMPTS = 3
) ();
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

    logic                       digit_valid;
    logic [DIGIT_W-1:0]         digit;
    logic                       submit;
    logic                       clear;
    logic [LEN_W-1:0]           pass_len;
    logic [MAX_LEN*DIGIT_W-1:0] pass_code;

    logic                       unlocked;
    logic                       fail_pulse;
    logic                       locked_out;
    logic                       busy;
    logic [LEN_W-1:0]           entry_count;
    logic [ATT_W-1:0]           attempts;

    // Front end / configuration side.
    modport master (
        output digit_valid, digit, submit, clear, pass_len, pass_code,
        input  unlocked, fail_pulse, locked_out, busy, entry_count, attempts
    );

    // Controller side.
    modport slave (
        input  digit_valid, digit, submit, clear, pass_len, pass_code,
        output unlocked, fail_pulse, locked_out, busy, entry_count, attempts
    );
endinterface

// File: rtl/passcode_controller.sv
// Keypad lock controller: buffers entered digits, checks length, compares the
// entry digit-by-digit against the stored passcode, counts failed attempts and
// enforces a timed lockout. All outputs come straight from registers.
module passcode_controller #(
    parameter int DIGIT_W        = 4,
    parameter int MAX_LEN        = 10,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    passcode_controller_if.slave  bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [LEN_W-1:0] MAX_LEN_L      = LEN_W'(MAX_LEN);
    localparam logic [ATT_W-1:0] MAX_ATTEMPTS_L = ATT_W'(MAX_ATTEMPTS);
    localparam logic [TMR_W-1:0] TIMER_LOAD     = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_COMPARE,
        ST_FAIL,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_t;

    state_t             r_state;
    logic [DIGIT_W-1:0] r_buf [MAX_LEN];
    logic [LEN_W-1:0]   r_entry_count;
    logic               r_overflow;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [ATT_W-1:0]   r_attempts;
    logic [TMR_W-1:0]   r_timer;
    logic               r_unlocked;
    logic               r_fail_pulse;
    logic               r_locked_out;
    logic               r_busy;

    logic               w_len_bad;
    logic [DIGIT_W-1:0] w_buf_digit;
    logic [DIGIT_W-1:0] w_code_digit;
    logic [ATT_W-1:0]   w_att_next;

    // Submit qualification, current compare operands and next failure count.
    always_comb begin
        w_len_bad    = (bus.pass_len == '0) || (bus.pass_len > MAX_LEN_L) ||
                       r_overflow || (r_entry_count != bus.pass_len);
        w_buf_digit  = r_buf[r_idx];
        w_code_digit = bus.pass_code[r_idx*DIGIT_W +: DIGIT_W];
        w_att_next   = r_attempts + ATT_W'(1);
    end

    // Controller FSM with registered status outputs.
    // NOTE: every register here is assigned with <= so all updates take effect
    // together at the clock edge regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_ENTRY;
            // NOTE: the digit buffer is small and must not leak a previous entry
            // after reset, so it is cleared along with the control state.
            for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= '0;
            r_entry_count <= '0;
            r_overflow    <= 1'b0;
            r_len         <= '0;
            r_idx         <= '0;
            r_attempts    <= '0;
            r_timer       <= '0;
            r_unlocked    <= 1'b0;
            r_fail_pulse  <= 1'b0;
            r_locked_out  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (bus.clear) begin
                        r_entry_count <= '0;
                        r_overflow    <= 1'b0;
                    end else if (bus.submit) begin
                        r_len <= bus.pass_len;
                        if (w_len_bad) begin
                            r_state      <= ST_FAIL;
                            r_fail_pulse <= 1'b1;
                        end else begin
                            r_state <= ST_COMPARE;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end else if (bus.digit_valid) begin
                        if (r_entry_count < MAX_LEN_L) begin
                            r_buf[r_entry_count] <= bus.digit;
                            r_entry_count        <= r_entry_count + LEN_W'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (w_buf_digit != w_code_digit) begin
                        r_state      <= ST_FAIL;
                        r_busy       <= 1'b0;
                        r_fail_pulse <= 1'b1;
                    end else if (r_idx == r_len - LEN_W'(1)) begin
                        r_state    <= ST_UNLOCKED;
                        r_busy     <= 1'b0;
                        r_unlocked <= 1'b1;
                        r_attempts <= '0;
                    end else begin
                        r_idx <= r_idx + LEN_W'(1);
                    end
                end
                ST_FAIL: begin
                    r_fail_pulse  <= 1'b0;
                    r_attempts    <= w_att_next;
                    r_entry_count <= '0;
                    r_overflow    <= 1'b0;
                    if (w_att_next == MAX_ATTEMPTS_L) begin
                        r_state      <= ST_LOCKOUT;
                        r_timer      <= TIMER_LOAD;
                        r_locked_out <= 1'b1;
                    end else begin
                        r_state <= ST_ENTRY;
                    end
                end
                ST_LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state      <= ST_ENTRY;
                        r_locked_out <= 1'b0;
                        r_attempts   <= '0;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_UNLOCKED: begin
                    if (bus.clear) begin
                        r_state       <= ST_ENTRY;
                        r_unlocked    <= 1'b0;
                        r_entry_count <= '0;
                        r_overflow    <= 1'b0;
                    end
                end
                default: r_state <= ST_ENTRY;
            endcase
        end
    end

    assign bus.unlocked    = r_unlocked;
    assign bus.fail_pulse  = r_fail_pulse;
    assign bus.locked_out  = r_locked_out;
    assign bus.busy        = r_busy;
    assign bus.entry_count = r_entry_count;
    assign bus.attempts    = r_attempts;
endmodule

// File: tb/tb_passcode_controller.sv
// Directed bench for passcode_controller: correct/incorrect codes, length
// mismatch, lockout timing, overflow, strobe priority and async reset.
module tb_passcode_controller;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    passcode_controller_if #(.DIGIT_W(4), .MAX_LEN(10), .MAX_ATTEMPTS(3)) bus ();

    passcode_controller #(
        .DIGIT_W(4), .MAX_LEN(10), .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    task automatic do_submit();
        bus.submit = 1'b1;
        tick();
        bus.submit = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    // Enter 1,2,3,4 and verify the unlock timing, then relock.
    task automatic unlock_ok(input string tag);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check({tag, "_count"}, bus.entry_count, 4);
        do_submit();
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, bus.busy, 1);
            check({tag, "_early_unlk"}, bus.unlocked, 0);
            tick();
        end
        check({tag, "_busy_done"}, bus.busy, 0);
        check({tag, "_unlocked"}, bus.unlocked, 1);
        check({tag, "_attempts"}, bus.attempts, 0);
        do_clear();
        check({tag, "_relock"}, bus.unlocked, 0);
        check({tag, "_clr_count"}, bus.entry_count, 0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset_n         = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = '0;
        bus.submit      = 1'b0;
        bus.clear       = 1'b0;
        bus.pass_len    = 4'd4;
        bus.pass_code   = 40'h00_0000_4321;
        tick();
        tick();
        check("rst_unlocked", bus.unlocked, 0);
        check("rst_fail", bus.fail_pulse, 0);
        check("rst_locked", bus.locked_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.entry_count, 0);
        check("rst_attempts", bus.attempts, 0);
        reset_n = 1'b1;
        tick();

        // Correct code unlocks after four compare cycles.
        unlock_ok("t1");

        // Mismatch at digit index 2: three busy cycles then a fail pulse.
        press(4'd1); press(4'd2); press(4'd9); press(4'd4);
        do_submit();
        for (int i = 0; i < 3; i++) begin
            check("t2_busy", bus.busy, 1);
            check("t2_no_fail", bus.fail_pulse, 0);
            tick();
        end
        check("t2_fail", bus.fail_pulse, 1);
        check("t2_busy_off", bus.busy, 0);
        tick();
        check("t2_fail_once", bus.fail_pulse, 0);
        check("t2_attempts", bus.attempts, 1);
        check("t2_count", bus.entry_count, 0);
        unlock_ok("t2u");

        // Too-short entry fails immediately, never goes busy; clear keeps attempts.
        press(4'd1); press(4'd2); press(4'd3);
        do_submit();
        check("t3_fail", bus.fail_pulse, 1);
        check("t3_busy", bus.busy, 0);
        tick();
        check("t3_fail_once", bus.fail_pulse, 0);
        check("t3_busy2", bus.busy, 0);
        check("t3_attempts", bus.attempts, 1);
        press(4'd7);
        do_clear();
        check("t3_clr_count", bus.entry_count, 0);
        check("t3_clr_attempts", bus.attempts, 1);
        unlock_ok("t3u");

        // Three failures lead to an eight-cycle lockout that ignores input.
        for (int a = 1; a <= 2; a++) begin
            press(4'd5);
            do_submit();
            check("t4_fail", bus.fail_pulse, 1);
            tick();
            check("t4_attempts", bus.attempts, a);
            check("t4_not_locked", bus.locked_out, 0);
        end
        press(4'd5);
        do_submit();
        check("t4_fail3", bus.fail_pulse, 1);
        check("t4_pre_lock", bus.locked_out, 0);
        tick();
        check("t4_fail3_once", bus.fail_pulse, 0);
        check("t4_attempts3", bus.attempts, 3);
        for (int i = 0; i < 8; i++) begin
            check("t4_locked", bus.locked_out, 1);
            check("t4_lock_count", bus.entry_count, 0);
            bus.digit_valid = (i % 2 == 0);
            bus.digit       = 4'd1;
            bus.submit      = (i == 3);
            tick();
        end
        bus.digit_valid = 1'b0;
        bus.submit      = 1'b0;
        check("t4_lock_end", bus.locked_out, 0);
        check("t4_att_clr", bus.attempts, 0);
        check("t4_count_after", bus.entry_count, 0);
        unlock_ok("t4u");

        // Eleven digits saturate the count; overflow forces a fail.
        bus.pass_len  = 4'd10;
        bus.pass_code = 40'h09_8765_4321;
        for (int i = 1; i <= 10; i++) press(4'(i % 10));
        check("t5_count10", bus.entry_count, 10);
        press(4'd7);
        check("t5_saturate", bus.entry_count, 10);
        do_submit();
        check("t5_ovf_fail", bus.fail_pulse, 1);
        check("t5_ovf_busy", bus.busy, 0);
        tick();
        check("t5_attempts", bus.attempts, 1);
        check("t5_count_clr", bus.entry_count, 0);

        // Exactly MAX_LEN matching digits unlock after ten compare cycles.
        for (int i = 1; i <= 10; i++) press(4'(i % 10));
        do_submit();
        for (int i = 0; i < 10; i++) begin
            check("t5_busy", bus.busy, 1);
            tick();
        end
        check("t5_unlocked", bus.unlocked, 1);
        check("t5_att_clr", bus.attempts, 0);
        do_clear();

        // A zero configured length always fails.
        bus.pass_len = 4'd0;
        do_submit();
        check("t5_len0_fail", bus.fail_pulse, 1);
        tick();
        bus.pass_len  = 4'd4;
        bus.pass_code = 40'h00_0000_4321;
        unlock_ok("t5u");

        // Clear beats submit in the same cycle.
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        bus.clear  = 1'b1;
        bus.submit = 1'b1;
        tick();
        bus.clear  = 1'b0;
        bus.submit = 1'b0;
        check("t6_count", bus.entry_count, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_fail", bus.fail_pulse, 0);
        tick();
        check("t6_busy2", bus.busy, 0);
        check("t6_fail2", bus.fail_pulse, 0);
        check("t6_unlocked", bus.unlocked, 0);

        // Async reset in the middle of a compare.
        press(4'd5);
        do_submit();
        tick();
        check("t6_pre_att", bus.attempts, 1);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        do_submit();
        tick();
        check("t6_mid_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_unlocked", bus.unlocked, 0);
        check("t6_rst_fail", bus.fail_pulse, 0);
        check("t6_rst_locked", bus.locked_out, 0);
        check("t6_rst_count", bus.entry_count, 0);
        check("t6_rst_att", bus.attempts, 0);
        reset_n = 1'b1;
        tick();
        press(4'd3);
        check("t6_entry_ok", bus.entry_count, 1);
        check("t6_idle_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
